// File: rtl/uart_pkg.sv
// Shared definitions for the serial transmit path: state codes and line levels.
package uart_pkg;

    // Frame sequencer state codes
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        START  = S_START,
        DATA   = S_DATA,
        PARITY = S_PARITY,
        STOP   = S_STOP
    } state_t;

    // Serial line levels
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick
// in the last clock of each period. Dropping en returns the count to zero.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Period counter, held at zero whenever the timer is not enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Parallel-to-serial frame transmitter: start bit, data LSB-first, optional
// even parity, stop bit(s). All outputs come straight from flip-flops.
//
// The bit timer is started in the accept cycle, so it runs one clock ahead
// of the line. Its tick therefore lands in the second-to-last clock of each
// line bit; registering it gives bit_last in the true last clock, and lets
// tx_done/tx_ready be registered while still appearing in that last clock.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic              stop_idx, stop_idx_nxt;
    logic              bit_last;
    logic              out_q, out_nxt;
    logic              ready_q, ready_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              par, par_nxt;
    logic              accept, tick, tick_en, last_stop, load;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign accept    = tx_valid & ready_q;
    assign tick_en   = accept | (busy_q & ~done_q);
    assign last_stop = (stop_idx == STOP_LAST);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .tick(tick)
    );

    // Next-state, next-output and datapath update for the frame sequencer
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        stop_idx_nxt = stop_idx;
        out_nxt      = out_q;
        ready_nxt    = ready_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        shreg_nxt    = shreg;
        par_nxt      = par;
        load         = 1'b0;

        case (state)
            IDLE: begin
                out_nxt   = IDLE_LEVEL;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                if (accept) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_last) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                    out_nxt   = shreg[0];
                end
            end
            DATA: begin
                if (bit_last) begin
                    shreg_nxt = shreg >> 1;
                    if (idx == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            out_nxt   = par;
                        end else begin
                            state_nxt    = STOP;
                            stop_idx_nxt = 1'b0;
                            out_nxt      = IDLE_LEVEL;
                        end
                    end else begin
                        idx_nxt = idx + IW'(1);
                        out_nxt = shreg_nxt[0];
                    end
                end
            end
            PARITY: begin
                if (bit_last) begin
                    state_nxt    = STOP;
                    stop_idx_nxt = 1'b0;
                    out_nxt      = IDLE_LEVEL;
                end
            end
            STOP: begin
                // One clock before the final stop clock: announce completion
                if (tick && last_stop) begin
                    ready_nxt = 1'b1;
                    done_nxt  = 1'b1;
                end
                if (bit_last) begin
                    if (!last_stop) begin
                        stop_idx_nxt = 1'b1;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        ready_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                out_nxt   = IDLE_LEVEL;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

        // Accepting a word: capture it and begin the start bit next cycle
        if (load) begin
            state_nxt    = START;
            shreg_nxt    = tx_data;
            par_nxt      = even_parity(tx_data);
            idx_nxt      = '0;
            stop_idx_nxt = 1'b0;
            out_nxt      = START_LEVEL;
            ready_nxt    = 1'b0;
            busy_nxt     = 1'b1;
        end
    end

    // Control and output registers; reset aborts any frame and idles the line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            stop_idx <= 1'b0;
            bit_last <= 1'b0;
            out_q    <= IDLE_LEVEL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            stop_idx <= stop_idx_nxt;
            bit_last <= tick;
            out_q    <= out_nxt;
            ready_q  <= ready_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // Word and parity holding registers; only read after a load
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
        par   <= par_nxt;
    end

    assign tx_out   = out_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: one instance without parity, one with.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_out, tx_busy, tx_done;
    logic [7:0] p_data;
    logic       p_valid;
    logic       p_ready, p_out, p_busy, p_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] cap_bits;
    int          cap_ndone, cap_first, cap_last, cap_busy_low;
    logic        cap_out0, cap_rdy0, cap_out40;

    uart_tx_serializer #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx_serializer #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)
    ) dut_p (
        .clk(clk), .rst(rst), .tx_data(p_data), .tx_valid(p_valid),
        .tx_ready(p_ready), .tx_out(p_out), .tx_busy(p_busy), .tx_done(p_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offer a word at a negedge, then watch nclk cycles starting with the
    // first clock after the accepting edge. Bits are sampled mid-bit.
    task automatic run_frame(input bit use_p, input logic [7:0] d, input int nclk,
                             input int chg_at, input logic [7:0] chg_d, input int drop_at);
        logic o, dn, bz, rd;
        cap_bits = '0; cap_ndone = 0; cap_first = -1; cap_last = -1;
        cap_busy_low = 0; cap_out0 = 1'b1; cap_rdy0 = 1'b1; cap_out40 = 1'b1;
        if (use_p) begin p_valid = 1'b1; p_data = d; end
        else begin tx_valid = 1'b1; tx_data = d; end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < nclk; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_at) begin
                if (use_p) p_valid = 1'b0; else tx_valid = 1'b0;
            end
            if (k == chg_at) begin
                if (use_p) p_data = chg_d; else tx_data = chg_d;
            end
            o  = use_p ? p_out  : tx_out;
            dn = use_p ? p_done : tx_done;
            bz = use_p ? p_busy : tx_busy;
            rd = use_p ? p_ready : tx_ready;
            if (k == 0) begin cap_out0 = o; cap_rdy0 = rd; end
            if (k == 40) cap_out40 = o;
            if ((k % CPB) == CPB / 2) cap_bits[k / CPB] = o;
            if (dn) begin
                cap_ndone++;
                if (cap_first < 0) cap_first = k;
                cap_last = k;
            end
            if (!bz) cap_busy_low++;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out"},   32'(tx_out),   32'd1);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_busy"},  32'(tx_busy),  32'd0);
        check({tag, "_done"},  32'(tx_done),  32'd0);
    endtask

    initial begin
        rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; p_valid = 1'b0; p_data = 8'h00;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        check_idle("t1_in_reset");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle("t1_idle");
        end

        // 2: 0xA5 without parity
        run_frame(1'b0, 8'hA5, 40, -1, 8'h00, 0);
        check("t2_start_out",   32'(cap_out0), 32'd0);
        check("t2_start_ready", 32'(cap_rdy0), 32'd0);
        check("t2_bits",        cap_bits,      32'b1101001010);
        check("t2_ndone",       cap_ndone,     1);
        check("t2_done_pos",    cap_first,     39);
        check("t2_busy_low",    cap_busy_low,  0);
        @(negedge clk);
        check_idle("t2_after");

        // 3: parity instance
        run_frame(1'b1, 8'hA5, 44, -1, 8'h00, 0);
        check("t3_a5_bits",     cap_bits,  32'b10101001010);
        check("t3_a5_ndone",    cap_ndone, 1);
        check("t3_a5_done_pos", cap_first, 43);
        @(negedge clk);
        check("t3_a5_idle_busy", 32'(p_busy), 32'd0);
        run_frame(1'b1, 8'h07, 44, -1, 8'h00, 0);
        check("t3_07_bits",     cap_bits,  32'b11000001110);
        check("t3_07_ndone",    cap_ndone, 1);
        check("t3_07_done_pos", cap_first, 43);
        @(negedge clk);

        // 4: back-to-back 0x01 then 0xFF with valid held
        run_frame(1'b0, 8'h01, 80, 0, 8'hFF, 40);
        check("t4_bits",      cap_bits,      32'b11111111101000000010);
        check("t4_ndone",     cap_ndone,     2);
        check("t4_done1",     cap_first,     39);
        check("t4_done2",     cap_last,      79);
        check("t4_busy_low",  cap_busy_low,  0);
        check("t4_start2",    32'(cap_out40), 32'd0);
        @(negedge clk);
        check_idle("t4_after");

        // 5: data changes mid-frame are ignored
        run_frame(1'b0, 8'hA5, 40, 10, 8'h00, 0);
        check("t5_bits",  cap_bits,  32'b1101001010);
        check("t5_ndone", cap_ndone, 1);
        @(negedge clk);

        // 6: asynchronous reset during data bit 3 (line low for 0xA5)
        tx_valid = 1'b1; tx_data = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("t6_pre_out",  32'(tx_out),  32'd0);
        check("t6_pre_busy", 32'(tx_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_idle("t6_async");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("t6_released");
        run_frame(1'b0, 8'h3C, 40, -1, 8'h00, 0);
        check("t6_bits",     cap_bits,  32'b1001111000);
        check("t6_ndone",    cap_ndone, 1);
        check("t6_done_pos", cap_first, 39);
        @(negedge clk);
        check_idle("t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
